// File: rtl/ysyx_220053_mem_arb_pkg.sv
// Shared definitions for the icache/dcache memory arbiter: FSM states,
// grant identifiers and default cache geometry.
package ysyx_220053_mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 64;
    localparam int unsigned LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    function automatic grant_e other_grant(input grant_e g);
        return (g == GNT_I) ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/ysyx_220053_rr_pick.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
module ysyx_220053_rr_pick
    import ysyx_220053_mem_arb_pkg::*;
(
    input  logic i_valid_i,
    input  logic d_valid_i,
    input  logic last_grant_i,
    output logic any_c_o,
    output logic grant_c_o
);

    always_comb begin
        any_c_o   = i_valid_i | d_valid_i;
        grant_c_o = GNT_I;
        if (i_valid_i && d_valid_i) begin
            grant_c_o = other_grant(grant_e'(last_grant_i));
        end else if (d_valid_i) begin
            grant_c_o = GNT_D;
        end
    end

endmodule

// File: rtl/ysyx_220053_mem_arb.sv
// Arbitrates icache and dcache line requests onto a single memory port,
// one transaction at a time with round-robin fairness.
module ysyx_220053_mem_arb
    import ysyx_220053_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_req_i,
    input  logic              i_valid_i,
    input  logic [LINE_W-1:0] i_wdata_i,
    output logic [LINE_W-1:0] i_rdata_o,
    output logic              i_ready_o,

    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_req_i,
    input  logic              d_valid_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    output logic [LINE_W-1:0] d_rdata_o,
    output logic              d_ready_o,

    output logic [ADDR_W-1:0] m_addr_o,
    output logic              m_req_o,
    output logic              m_valid_o,
    output logic [LINE_W-1:0] m_wdata_o,
    input  logic [LINE_W-1:0] m_rdata_i,
    input  logic              m_ready_i,

    output logic              busy_o
);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic              pick_any_c;
    logic              pick_gnt_c;

    ysyx_220053_rr_pick u_rr_pick (
        .i_valid_i    (i_valid_i),
        .d_valid_i    (d_valid_i),
        .last_grant_i (last_grant_q),
        .any_c_o      (pick_any_c),
        .grant_c_o    (pick_gnt_c)
    );

    // Memory request is always driven from the latched copy; m_valid_o qualifies it.
    assign m_addr_o  = addr_q;
    assign m_req_o   = req_q;
    assign m_wdata_o = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            owner_q      <= GNT_I;
            addr_q       <= '0;
            req_q        <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            wdata_q      <= wdata_d;
        end
    end

    // Outputs are forced low while rst is held, even mid-transaction.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        req_d        = req_q;
        wdata_d      = wdata_q;
        m_valid_o    = 1'b0;
        busy_o       = 1'b0;
        i_ready_o    = 1'b0;
        d_ready_o    = 1'b0;
        i_rdata_o    = '0;
        d_rdata_o    = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_any_c) begin
                    owner_d      = grant_e'(pick_gnt_c);
                    last_grant_d = grant_e'(pick_gnt_c);
                    state_d      = BUSY;
                    if (pick_gnt_c == GNT_D) begin
                        addr_d  = d_addr_i;
                        req_d   = d_req_i;
                        wdata_d = d_wdata_i;
                    end else begin
                        addr_d  = i_addr_i;
                        req_d   = i_req_i;
                        wdata_d = i_wdata_i;
                    end
                end
            end
            BUSY: begin
                m_valid_o = !rst;
                busy_o    = !rst;
                if (m_ready_i) begin
                    state_d = DONE;
                    if (!rst) begin
                        if (owner_q == GNT_D) begin
                            d_ready_o = 1'b1;
                            d_rdata_o = m_rdata_i;
                        end else begin
                            i_ready_o = 1'b1;
                            i_rdata_o = m_rdata_i;
                        end
                    end
                end
            end
            DONE: begin
                busy_o  = !rst;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/ysyx_220053_mem_arb.md
YSYX_220053_MEM_ARB -- requirements
Module: ysyx_220053_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: width of line address on all ports.
REQ-002 SHALL have parameter LINE_W, default 128: cache-line data width on all ports.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports i_addr_i, input, ADDR_W: icache line address.
REQ-006 SHALL have ports i_req_i, input, 1: icache access type (0 read, 1 write).
REQ-007 SHALL have ports i_valid_i, input, 1: icache request pending.
REQ-008 SHALL have ports i_wdata_i, input, LINE_W: icache write line.
REQ-009 SHALL have ports i_rdata_o, output, LINE_W, and i_ready_o, output, 1: icache read line and one-cycle completion pulse.
REQ-010 SHALL have ports d_addr_i, d_req_i, d_valid_i, d_wdata_i (inputs) and d_rdata_o, d_ready_o (outputs): dcache equivalents of REQ-005..009.
REQ-011 SHALL have ports m_addr_o (ADDR_W), m_req_o (1), m_valid_o (1), m_wdata_o (LINE_W), outputs: shared memory-side request.
REQ-012 SHALL have ports m_rdata_i (LINE_W), m_ready_i (1), inputs: memory read line and one-cycle completion pulse.
REQ-013 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 In IDLE, with no valid inputs, the arbiter SHALL remain in IDLE with m_valid_o=0.
REQ-016 In IDLE, with exactly one valid input, the arbiter SHALL grant it, latch addr/req/wdata into internal registers, and go to BUSY next cycle.
REQ-017 In IDLE, with both valid inputs, the arbiter SHALL grant the requester not granted last (round-robin via a last_grant register).
REQ-018 In BUSY, m_valid_o SHALL be 1, and m_addr_o/m_req_o/m_wdata_o SHALL be driven from the latched registers, held stable until m_ready_i.
REQ-019 In BUSY, on m_ready_i=1, the granted requester's ready SHALL pulse high in that same cycle with rdata = m_rdata_i (combinational pass-through), and the FSM SHALL go to DONE.
REQ-020 The non-granted requester's ready SHALL stay 0 and its rdata SHALL be 0.
REQ-021 DONE SHALL last exactly one cycle with m_valid_o=0 and no new grant, then return to IDLE; this gives requesters one cycle to drop valid.
REQ-022 A requester's valid still high in the IDLE after DONE SHALL be treated as a new request.
REQ-023 Changes to a granted requester's inputs during BUSY SHALL be ignored (latched values only).
REQ-024 A requester dropping valid during BUSY SHALL NOT abort the memory transaction; its ready pulse SHALL still be issued.
REQ-025 m_ready_i outside BUSY SHALL be ignored.
REQ-026 last_grant SHALL update on each grant.
REQ-027 Minimum request-to-ready latency SHALL be 2 cycles (grant cycle plus one BUSY cycle with immediate m_ready_i); back-to-back grants are spaced at least 3 cycles apart.
REQ-028 No starvation: with both requesters continuously valid, grants SHALL strictly alternate.

Reset
REQ-029 While rst=1, state SHALL be IDLE and last_grant SHALL be icache, so dcache wins the first tie.
REQ-030 While rst=1, latched registers SHALL be 0.
REQ-031 While rst=1, m_valid_o, i_ready_o, d_ready_o and busy_o SHALL be 0.
REQ-032 Reset asserted during BUSY SHALL abandon the transaction with no ready pulse; a later m_ready_i SHALL be ignored.

Structure
REQ-033 State encoding and the grant identifiers (GNT_I, GNT_D) SHALL reside in a shared package with the cache constants.
REQ-034 SHALL contain one sub-module ysyx_220053_rr_pick (2-way round-robin selector: valids, last_grant -> grant).

Verification
REQ-035 Single dcache read: d_valid_i=1, d_addr_i=0x80001000; memory asserts m_ready_i 3 cycles later with rdata 0x1122..FF -> m_addr_o=0x80001000, m_req_o=0, d_ready_o pulses once with that data, i_ready_o stays 0.
REQ-036 Simultaneous requests after reset: icache 0x80000000, dcache 0x80002000 -> dcache granted first; icache is granted in the IDLE following DONE.
REQ-037 Continuous contention, 6 transactions -> grant order D,I,D,I,D,I.
REQ-038 Dcache write with wdata 0xDEAD_BEEF_..., d_wdata_i changed mid-BUSY -> m_wdata_o keeps the original value until m_ready_i.
REQ-039 rst pulsed during BUSY, then m_ready_i=1 -> no ready pulse; busy_o=0; m_valid_o=0.
REQ-040 Spurious m_ready_i in IDLE -> no ready pulse, state unchanged.
